// File: rtl/gpio_bus_initiator.sv
// gpio_bus_initiator
//   Turns a queued stream of host register commands into single-cycle
//   strobes on the GPIO register bus, and returns read data over a
//   response port.
//
//   Commands are buffered in a small FIFO. One access is on the bus at a
//   time, so responses come back in the same order as the commands.
//
// Ports
//   reg_clk, reset_reg_N      clock and asynchronous active-low reset
//   cmd_valid/cmd_ready       command handshake
//   cmd_write/addr/data       command payload (1 = write, 0 = read)
//   rsp_valid/rsp_ready       read response handshake
//   rsp_data                  captured read data
//   busaddress, busdata_out   register bus address / write data (held)
//   write_reg, read_reg       single-cycle bus strobes
//   busdata_in                read data returned by the slaves
//   busy                      FIFO non-empty or access in progress
//   dbg_state_o               current FSM state
//
// Handshake: a transfer happens on a rising edge where valid and ready
// are both high. A producer holds valid and its payload stable until that
// edge. On the command port, cmd_ready depends only on FIFO occupancy and
// never on cmd_valid. On the response port, rsp_valid and rsp_data stay
// stable until rsp_ready is seen.
module gpio_bus_initiator #(
  parameter int AddrWidth   = 16,
  parameter int BusWidth    = 32,
  parameter int FifoDepth   = 4,
  parameter int ReadLatency = 3
) (
  input  logic                 reg_clk,
  input  logic                 reset_reg_N,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_write,
  input  logic [AddrWidth-1:0] cmd_addr,
  input  logic [BusWidth-1:0]  cmd_data,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [BusWidth-1:0]  rsp_data,
  output logic [AddrWidth-1:0] busaddress,
  output logic [BusWidth-1:0]  busdata_out,
  output logic                 write_reg,
  output logic                 read_reg,
  input  logic [BusWidth-1:0]  busdata_in,
  output logic                 busy,
  output logic [2:0]           dbg_state_o
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WSTROBE = 3'd1,
    ST_GAP     = 3'd2,
    ST_RSTROBE = 3'd3,
    ST_RWAIT   = 3'd4,
    ST_RESP    = 3'd5
  } state_e;

  localparam int PtrW   = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
  localparam int CntW   = PtrW + 1;
  localparam int EntryW = 1 + AddrWidth + BusWidth;
  localparam logic [3:0] LatLoad = 4'(ReadLatency - 1);

  // ---------------------------------------------------------------------
  // Command FIFO
  // ---------------------------------------------------------------------
  logic [EntryW-1:0]    mem_q [FifoDepth];
  logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]      count_q, count_d;
  logic                 fifo_empty, fifo_full;
  logic                 push, pop;
  logic [EntryW-1:0]    head;
  logic                 head_write;
  logic [AddrWidth-1:0] head_addr;
  logic [BusWidth-1:0]  head_data;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CntW'(FifoDepth));
  assign cmd_ready  = !fifo_full;
  assign push       = cmd_valid && cmd_ready;

  assign head       = mem_q[rd_ptr_q];
  assign head_write = head[EntryW-1];
  assign head_addr  = head[BusWidth +: AddrWidth];
  assign head_data  = head[BusWidth-1:0];

  // Storage carries no reset; occupancy is tracked by count_q alone.
  always_ff @(posedge reg_clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {cmd_write, cmd_addr, cmd_data};
    end
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Depth is a power of two, so the pointers wrap naturally.
  always_ff @(posedge reg_clk or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_d;
    end
  end

  // ---------------------------------------------------------------------
  // Bus FSM
  // ---------------------------------------------------------------------
  state_e               state_q;
  logic [3:0]           lat_q;
  logic                 gap_after_rd_q;
  logic [AddrWidth-1:0] busaddress_q;
  logic [BusWidth-1:0]  busdata_out_q;
  logic [BusWidth-1:0]  rsp_data_q;
  logic                 write_reg_q, read_reg_q, rsp_valid_q, busy_q;
  logic                 can_issue, fsm_idle_next, busy_d;

  // The low cycle in GAP is also the issue point for the next command,
  // so back-to-back writes strobe every second cycle. After a read
  // response, GAP returns to IDLE first, which gives one extra idle cycle
  // before the next strobe.
  assign can_issue     = (state_q == ST_IDLE) ||
                         ((state_q == ST_GAP) && !gap_after_rd_q);
  assign pop           = can_issue && !fifo_empty;
  assign fsm_idle_next = ((state_q == ST_IDLE) || (state_q == ST_GAP)) && !pop;
  assign busy_d        = (count_d != '0) || !fsm_idle_next;

  always_ff @(posedge reg_clk or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      state_q        <= ST_IDLE;
      lat_q          <= '0;
      gap_after_rd_q <= 1'b0;
      busaddress_q   <= '0;
      busdata_out_q  <= '0;
      rsp_data_q     <= '0;
      write_reg_q    <= 1'b0;
      read_reg_q     <= 1'b0;
      rsp_valid_q    <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      busy_q <= busy_d;
      case (state_q)
        ST_IDLE, ST_GAP: begin
          gap_after_rd_q <= 1'b0;
          if (pop) begin
            busaddress_q <= head_addr;
            if (head_write) begin
              busdata_out_q <= head_data;
              write_reg_q   <= 1'b1;
              state_q       <= ST_WSTROBE;
            end else begin
              read_reg_q <= 1'b1;
              lat_q      <= LatLoad;
              state_q    <= ST_RSTROBE;
            end
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_WSTROBE: begin
          write_reg_q <= 1'b0;
          state_q     <= ST_GAP;
        end
        // The counter also counts down here, so data is sampled exactly
        // ReadLatency edges after the strobe rose.
        ST_RSTROBE: begin
          read_reg_q <= 1'b0;
          if (lat_q == 4'd0) begin
            rsp_data_q  <= busdata_in;
            rsp_valid_q <= 1'b1;
            state_q     <= ST_RESP;
          end else begin
            lat_q   <= lat_q - 4'd1;
            state_q <= ST_RWAIT;
          end
        end
        ST_RWAIT: begin
          if (lat_q == 4'd0) begin
            rsp_data_q  <= busdata_in;
            rsp_valid_q <= 1'b1;
            state_q     <= ST_RESP;
          end else begin
            lat_q <= lat_q - 4'd1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q    <= 1'b0;
            gap_after_rd_q <= 1'b1;
            state_q        <= ST_GAP;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busaddress  = busaddress_q;
  assign busdata_out = busdata_out_q;
  assign write_reg   = write_reg_q;
  assign read_reg    = read_reg_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign busy        = busy_q;
  assign dbg_state_o = state_q;

endmodule
